// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller: latches two packed-BCD operands and adds them
// one digit per clock, LSD first, rippling the decimal carry through a register.
//
// state  | meaning
// S_IDLE | waiting for start; operands, carry-in and error flag latched on accept
// S_ADD  | one digit added per cycle, index runs 0..DIGITS-1
// S_FIN  | done pulses for this single cycle, then back to S_IDLE
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                cin,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   output logic [4*DIGITS-1:0] sum,
   output logic                cout,
   output logic                busy,
   output logic                done,
   output logic                err
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = $clog2(DIGITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_FIN} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            bad_digit;
   logic [3:0]      a_nib, b_nib, dig_sum;
   logic [4:0]      dig_t;
   logic            dig_carry;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   // Shared single-digit BCD add stage; +6 skips the six unused 4-bit codes
   always_comb begin
      a_nib = a_q[{idx_q, 2'b00} +: 4];
      b_nib = b_q[{idx_q, 2'b00} +: 4];
      dig_t = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
      if (dig_t > 5'd9) begin
         dig_sum   = dig_t[3:0] + 4'd6;
         dig_carry = 1'b1;
      end else begin
         dig_sum   = dig_t[3:0];
         dig_carry = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               sum_d   = '0;
               if (bad_digit) begin
                  err_d   = 1'b1;
                  cout_d  = 1'b0;
                  state_d = S_FIN;
               end else begin
                  err_d   = 1'b0;
                  state_d = S_ADD;
               end
            end
         end
         S_ADD: begin
            sum_d[{idx_q, 2'b00} +: 4] = dig_sum;
            carry_d = dig_carry;
            if (idx_q == LAST_IDX) begin
               cout_d  = dig_carry;
               state_d = S_FIN;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_d = (state_d == S_ADD);
      done_d = (state_d == S_FIN);
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: directed cases plus random operands
// compared against a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;
   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         cin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] sum;
   logic         cout, busy, done, err;

   int n_tests = 0;
   int n_fail  = 0;

   bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .cin(cin), .a(a), .b(b),
      .sum(sum), .cout(cout), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: convert to integers, add, convert back
   function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                                 output logic [W-1:0] s, output logic co, output logic e);
      longint va = 0, vb = 0, vs, p10 = 1;
      e = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (av[4*i +: 4] > 9 || bv[4*i +: 4] > 9) e = 1'b1;
         va  = va * 10 + longint'(av[4*i +: 4]);
         vb  = vb * 10 + longint'(bv[4*i +: 4]);
         p10 = p10 * 10;
      end
      s  = '0;
      co = 1'b0;
      if (!e) begin
         vs = va + vb + longint'(ci);
         co = (vs >= p10);
         vs = vs % p10;
         for (int i = 0; i < DIGITS; i++) begin
            s[4*i +: 4] = 4'(vs % 10);
            vs = vs / 10;
         end
      end
   endfunction

   // jam=1 keeps start high with another operand while busy and during done
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input bit jam);
      logic [W-1:0] es;
      logic         eco, ee;
      int           lat;
      model(av, bv, ci, es, eco, ee);
      @(negedge clk);
      a = av; b = bv; cin = ci; start = 1'b1;
      @(posedge clk); #1;
      if (jam) begin
         a = 16'h9999; b = 16'h9999; cin = 1'b1;
      end else begin
         start = 1'b0;
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      chk("busy_after_accept", {31'b0, busy}, {31'b0, !ee});
      lat = 0;
      while (!done && lat <= 3 * DIGITS) begin
         chk("busy_while_adding", {31'b0, busy}, 32'd1);
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, ee ? 0 : DIGITS);
      chk("done_seen", {31'b0, done}, 32'd1);
      chk("sum", {16'b0, sum}, {16'b0, es});
      chk("cout", {31'b0, cout}, {31'b0, eco});
      chk("err", {31'b0, err}, {31'b0, ee});
      chk("busy_at_done", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_single_pulse", {31'b0, done}, 32'd0);
      if (jam) begin
         @(posedge clk); #1;
         chk("jam_not_executed", {31'b0, busy}, 32'd0);
         chk("jam_sum_held", {16'b0, sum}, {16'b0, es});
         chk("jam_no_done", {31'b0, done}, 32'd0);
      end
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      #12;
      chk("rst_sum", {16'b0, sum}, 32'd0);
      chk("rst_flags", {27'b0, cout, busy, done, err}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      do_op(16'h1234, 16'h5678, 1'b0, 0);
      do_op(16'h9999, 16'h0001, 1'b0, 0);
      do_op(16'h9999, 16'h9999, 1'b1, 0);
      do_op(16'h0000, 16'h0000, 1'b0, 0);
      do_op(16'h12A4, 16'h0001, 1'b0, 0);
      do_op(16'h0005, 16'h0005, 1'b0, 0);
      do_op(16'h4321, 16'h1111, 1'b0, 1);

      // Reset mid-operation
      @(negedge clk);
      a = 16'h5555; b = 16'h5555; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_sum", {16'b0, sum}, 32'd0);
      chk("midrst_flags", {27'b0, cout, busy, done, err}, 32'd0);
      for (int i = 0; i < DIGITS + 2; i++) begin
         @(posedge clk); #1;
         chk("midrst_no_done", {31'b0, done}, 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < DIGITS + 2; i++) begin
         @(posedge clk); #1;
         chk("postrst_idle", {30'b0, busy, done}, 32'd0);
      end
      do_op(16'h0050, 16'h0050, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < DIGITS; i++) begin
            ra[4*i +: 4] = 4'($urandom_range(0, 9));
            rb[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
         if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
         do_op(ra, rb, 1'($urandom), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
Digit-serial multi-digit BCD adder controller. It latches two DIGITS-digit BCD operands on a start request and drives one shared single-digit BCD add stage, one digit per clock, least-significant digit first. The block chains the decimal carry through a register, assembles the result and signals completion with a done pulse. It sits between operand sources (switch/register front end) and the 7-segment display path.

Parameters:
DIGITS, 4, number of BCD digits per operand (legal 2..8).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request to begin an addition; sampled only in IDLE.
cin  input  1  decimal carry-in to digit 0; latched with the operands.
a  input  4*DIGITS  operand A, packed BCD; digit i is a[4i+3:4i].
b  input  4*DIGITS  operand B, packed BCD.
sum  output  4*DIGITS  result, packed BCD.
cout  output  1  decimal carry out of the most-significant digit.
busy  output  1  high while digits are being processed.
done  output  1  one-cycle pulse when sum/cout are valid.
err  output  1  high when the last request had an invalid digit (>9).

Behaviour:
- Reset (async, reset_n=0): state=IDLE; sum=0, cout=0, busy=0, done=0, err=0; digit index=0; carry register=0; operand registers=0. This takes effect immediately, including mid-operation. An in-flight addition is discarded and no done pulse is produced.
- States: IDLE, ADD, FIN.
- IDLE: if start=1 at the clock edge:
  - Latch a, b and cin.
  - Clear index to 0 and sum to 0.
  - Check every digit of a and b. If any digit is >9, set err=1, cout=0 and go to FIN; no digit is processed.
  - Otherwise set err=0 and busy=1, and go to ADD.
- ADD (one digit per cycle, digit = index):
  - t = A[idx] + B[idx] + carry (5-bit).
  - If t > 9: digit = t + 6 (low 4 bits), carry' = 1. Otherwise digit = t, carry' = 0.
  - At the edge, write sum[idx] and update the carry register.
  - If idx = DIGITS-1: cout = carry', busy = 0, go to FIN. Otherwise idx+1.
- FIN: done=1 for exactly this cycle, then return to IDLE unconditionally. A start during FIN is ignored and must be re-asserted in IDLE.
- Latency: start accepted at edge 0. busy=1 from edge 0 through edge DIGITS. done is high in the cycle after edge DIGITS and falls at edge DIGITS+1, so start-to-done is DIGITS+1 edges. On the error path, done is high in the cycle after edge 0.
- sum, cout and err hold their values from FIN until the next accepted start, which clears sum. Partial sum digits are visible while busy; consumers must use sum only on done.
- start while busy (ADD) or in FIN is ignored. Changes on a, b or cin after acceptance have no effect.
- Maximum result: 10^DIGITS - 1 + 10^DIGITS - 1 + 1 gives sum = all 9s with cout=1. There is no other overflow indication.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start pulsed → busy for 4 cycles; done on the 5th edge window; sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1 (carry ripples through all four digits).
- a=0x9999, b=0x9999, cin=1 → sum=0x9999, cout=1; then a=0x0000, b=0x0000, cin=0 → sum=0x0000, cout=0, confirming the carry register is cleared between operations.
- a=0x12A4, b=0x0001 → err=1, busy stays 0, done one cycle after acceptance, sum=0x0000, cout=0. A following valid request (0x0005+0x0005) → err=0, sum=0x0010.
- Start 0x4321+0x1111, then re-pulse start with 0x9999+0x9999 while busy, and again in FIN → first result 0x5432 unaffected; only one done pulse; the second request is not executed.
- Reset mid-operation: start 0x5555+0x5555 and drop reset_n after 2 cycles → all outputs 0 immediately, no done pulse. After release, 0x0050+0x0050 → sum=0x0100, cout=0.
